// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: scheduler state encoding,
// UART register map and status-word bit positions used by the peripheral block.
package uart_pkg;

  // Scheduler FSM states
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } tx_state_t;

  // UART register addresses in the peripheral map
  localparam logic [31:0] UART_TX_ADDR     = 32'h4000_0018;
  localparam logic [31:0] UART_RX_ADDR     = 32'h4000_001C;
  localparam logic [31:0] UART_STATUS_ADDR = 32'h4000_0020;

  // Bit positions of the TX scheduler flags inside the UART status word
  localparam int STAT_TX_EMPTY   = 0;
  localparam int STAT_TX_FULL    = 1;
  localparam int STAT_TX_OVF     = 2;
  localparam int STAT_TX_TIMEOUT = 3;
  localparam int STAT_TX_BUSY    = 4;

endpackage

// File: rtl/sync_fifo.sv
// Byte-wide synchronous FIFO with registered occupancy and a sticky overflow
// flag. A push into a full FIFO is still accepted when a pop happens in the
// same cycle; otherwise the byte is dropped and ovf is raised.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    wr_data,
  input  logic          clr_ovf,
  output logic [7:0]    rd_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          ovf
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          pop_ok;
  logic          push_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rd_data = mem[rd_ptr];

  // Storage write port
  // NOTE: the data array has no reset; contents are meaningless until
  // written, and leaving it out keeps the array mappable to plain RAM.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers, occupancy and sticky overflow
  // NOTE: every register here uses non-blocking assignment so all state
  // updates see the pre-edge values, matching the hardware.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push_ok && !pop_ok) begin
        count <= count + (AW+1)'(1);
      end else if (pop_ok && !push_ok) begin
        count <= count - (AW+1)'(1);
      end
      // A new drop wins over a simultaneous clear
      if (push && !push_ok) begin
        ovf <= 1'b1;
      end else if (clr_ovf) begin
        ovf <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Queues CPU bytes for the UART transmitter and launches them one at a time:
// a single tx_start pulse per byte, only when the UART is idle, then waits for
// the frame to start and finish. A start that never raises tx_busy within
// BUSY_TIMEOUT cycles is abandoned and flagged in timeout_err.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int AW           = 4,
  parameter int BUSY_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [7:0]  wr_data,
  input  logic        clr_ovf,
  input  logic        tx_busy,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count,
  output logic        ovf,
  output logic        timeout_err
);

  localparam int TW = $clog2(BUSY_TIMEOUT + 1);

  tx_state_t     state;
  tx_state_t     next_state;
  logic [TW-1:0] timer;
  logic          pop;
  logic          timed_out;
  logic [7:0]    head_data;

  sync_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (wr_en),
    .pop     (pop),
    .wr_data (wr_data),
    .clr_ovf (clr_ovf),
    .rd_data (head_data),
    .full    (full),
    .empty   (empty),
    .count   (count),
    .ovf     (ovf)
  );

  // Next-state and launch decode
  // NOTE: every output of this block gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    tx_start   = 1'b0;
    pop        = 1'b0;
    timed_out  = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && !tx_busy) begin
          next_state = LAUNCH;
        end
      end
      LAUNCH: begin
        tx_start   = 1'b1;
        pop        = 1'b1;
        next_state = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          next_state = WAIT_DONE;
        end else if (timer == TW'(BUSY_TIMEOUT)) begin
          timed_out  = 1'b1;
          next_state = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Busy-wait timer: cleared on launch, counts idle cycles in WAIT_BUSY
  always_ff @(posedge clk) begin
    if (!reset) begin
      timer <= '0;
    end else if (state == LAUNCH) begin
      timer <= '0;
    end else if (state == WAIT_BUSY && !tx_busy && !timed_out) begin
      timer <= timer + TW'(1);
    end
  end

  // Byte latch for the UART (captured on entry to LAUNCH) and sticky timeout
  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_data     <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == IDLE && next_state == LAUNCH) begin
        tx_data <= head_data;
      end
      // A new timeout wins over a simultaneous clear
      if (timed_out) begin
        timeout_err <= 1'b1;
      end else if (clr_ovf) begin
        timeout_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler. Pushed bytes go into an expected
// queue; a monitor pops and compares on every tx_start. A small UART model
// raises tx_busy one cycle after a start and holds it for ten cycles.
module tb_uart_tx_scheduler;

  localparam int DEPTH        = 16;
  localparam int AW           = 4;
  localparam int BUSY_TIMEOUT = 15;

  logic        clk;
  logic        reset;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic        clr_ovf;
  logic        tx_busy;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        full;
  logic        empty;
  logic [AW:0] count;
  logic        ovf;
  logic        timeout_err;

  logic force_busy;
  logic model_busy;
  logic model_en;

  assign tx_busy = force_busy | model_busy;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] exp_q[$];

  int cyc        = 0;
  int fall_cyc   = 0;
  int start_cnt  = 0;
  bit gap_armed  = 0;
  bit gap_chk_en = 0;
  bit prev_start = 0;
  bit prev_busy  = 0;

  uart_tx_scheduler #(
    .DEPTH        (DEPTH),
    .AW           (AW),
    .BUSY_TIMEOUT (BUSY_TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .clr_ovf     (clr_ovf),
    .tx_busy     (tx_busy),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .full        (full),
    .empty       (empty),
    .count       (count),
    .ovf         (ovf),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b, input bit accept);
    wr_en   = 1'b1;
    wr_data = b;
    if (accept) exp_q.push_back(b);
    step();
    wr_en = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
  endtask

  // Wait until all expected bytes have gone out and the link is quiet
  task automatic drain();
    int quiet = 0;
    int guard = 0;
    while (quiet < 20 && guard < 3000) begin
      @(negedge clk);
      guard++;
      if (tx_start || tx_busy || exp_q.size() != 0) quiet = 0;
      else quiet++;
    end
    check("drain_queue_empty", 32'(exp_q.size()), 0);
    step();
  endtask

  // UART model: busy one cycle after a start, held for ten cycles
  initial begin
    model_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start && model_en) begin
        @(posedge clk);
        #1;
        model_busy = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        model_busy = 1'b0;
      end
    end
  end

  // Output monitor and scoreboard
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!gap_chk_en) gap_armed = 0;
      if (prev_busy && !tx_busy) begin
        fall_cyc  = cyc;
        gap_armed = 1;
      end
      if (tx_start) begin
        start_cnt++;
        check("start_repeat", 32'(prev_start), 0);
        check("start_while_busy", 32'(tx_busy), 0);
        check("start_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check("tx_data", 32'(tx_data), 32'(exp_q.pop_front()));
        if (gap_chk_en && gap_armed) check("busy_to_start_gap", 32'(cyc - fall_cyc), 2);
        gap_armed = 0;
      end
      prev_start = tx_start;
      prev_busy  = tx_busy;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s0;
    int g;
    reset      = 1'b0;
    wr_en      = 1'b0;
    wr_data    = '0;
    clr_ovf    = 1'b0;
    force_busy = 1'b0;
    model_en   = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    check("rst_count", 32'(count), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_ovf", 32'(ovf), 0);
    check("rst_timeout", 32'(timeout_err), 0);
    check("rst_tx_start", 32'(tx_start), 0);
    check("rst_tx_data", 32'(tx_data), 0);
    reset = 1'b1;
    step();

    // Single byte: start exactly one cycle after the push edge
    push(8'hA5, 1);
    check("single_count", 32'(count), 1);
    check("single_empty", 32'(empty), 0);
    check("single_no_early_start", 32'(tx_start), 0);
    step();
    check("single_start", 32'(tx_start), 1);
    check("single_data", 32'(tx_data), 32'hA5);
    step();
    check("single_start_one_cycle", 32'(tx_start), 0);
    check("single_count_after", 32'(count), 0);
    check("single_empty_after", 32'(empty), 1);
    drain();

    // Burst of five with two-cycle gap after each busy fall
    gap_chk_en = 1;
    s0 = start_cnt;
    for (int i = 1; i <= 5; i++) push(8'(i), 1);
    drain();
    gap_chk_en = 0;
    check("burst_starts", 32'(start_cnt - s0), 5);

    // Overflow with the UART held busy
    force_busy = 1'b1;
    for (int i = 0; i < 17; i++) begin
      push(8'(i), i < 16);
      if (i == 15) begin
        check("ovf_full_at_16", 32'(full), 1);
        check("ovf_count_at_16", 32'(count), 16);
        check("ovf_not_yet", 32'(ovf), 0);
      end
    end
    check("ovf_set", 32'(ovf), 1);
    check("ovf_count_held", 32'(count), 16);
    check("ovf_full_held", 32'(full), 1);
    force_busy = 1'b0;
    drain();
    check("ovf_sticky", 32'(ovf), 1);
    check("ovf_empty_after", 32'(empty), 1);
    pulse_clr();
    check("ovf_cleared", 32'(ovf), 0);

    // Full FIFO with a push in the LAUNCH cycle
    force_busy = 1'b1;
    for (int i = 0; i < 16; i++) push(8'h80 + 8'(i), 1);
    check("pp_full", 32'(full), 1);
    force_busy = 1'b0;
    step();
    check("pp_launch", 32'(tx_start), 1);
    push(8'h77, 1);
    check("pp_count", 32'(count), 16);
    check("pp_full_kept", 32'(full), 1);
    check("pp_no_ovf", 32'(ovf), 0);
    drain();
    check("pp_empty_after", 32'(empty), 1);

    // Busy timeout: first byte abandoned, second launches normally
    model_en = 1'b0;
    push(8'h3C, 1);
    push(8'h5A, 1);
    check("to_launch", 32'(tx_start), 1);
    repeat (16) step();
    check("to_not_yet", 32'(timeout_err), 0);
    step();
    check("to_set", 32'(timeout_err), 1);
    model_en = 1'b1;
    step();
    check("to_next_launch", 32'(tx_start), 1);
    check("to_next_data", 32'(tx_data), 32'h5A);
    drain();
    check("to_sticky", 32'(timeout_err), 1);
    pulse_clr();
    check("to_cleared", 32'(timeout_err), 0);

    // Reset in the middle of a frame
    s0 = start_cnt;
    for (int i = 0; i < 8; i++) push(8'h10 + 8'(i), 1);
    check("mid_count", 32'(count), 7);
    check("mid_busy", 32'(tx_busy), 1);
    reset = 1'b0;
    step();
    reset = 1'b1;
    exp_q.delete();
    check("mr_count", 32'(count), 0);
    check("mr_empty", 32'(empty), 1);
    check("mr_full", 32'(full), 0);
    check("mr_ovf", 32'(ovf), 0);
    check("mr_tx_start", 32'(tx_start), 0);
    check("mr_tx_data", 32'(tx_data), 0);
    push(8'h99, 1);
    g = 0;
    while (tx_busy && g < 40) begin
      check("mr_no_launch_busy", 32'(tx_start), 0);
      step();
      g++;
    end
    check("mr_busy_dropped", 32'(tx_busy), 0);
    drain();
    check("mr_starts", 32'(start_cnt - s0), 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
